// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage: opcodes, condition codes,
// the queued-entry layout and the head classification helpers.
package alu_wb_stage_pkg;

    localparam int WB_DEPTH = 2;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SHL = 4'h6,
        ALU_SHR = 4'h7,
        ALU_CND = 4'h8
    } alu_action_e;

    localparam logic [1:0] CND_EQ      = 2'd0;
    localparam logic [1:0] CND_LESS    = 2'd1;
    localparam logic [1:0] CND_GREATER = 2'd2;
    localparam logic [1:0] CND_NONE    = 2'd3;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  action;
        logic [3:0]  dst;
        logic        wen;
    } wb_entry_t;

    function automatic logic is_cnd(input logic [3:0] action);
        return action == ALU_CND;
    endfunction

    // Condition results go to the condition register, never to the register file.
    function automatic logic needs_rf(input wb_entry_t e);
        return e.wen && !is_cnd(e.action);
    endfunction

endpackage

// File: rtl/alu_wb_stage_wb_fifo.sv
// In-order register FIFO for writeback entries; exposes the head and every
// slot in age order (index 0 = oldest) for the forwarding scan.
module wb_fifo
    import alu_wb_stage_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output wb_entry_t       head,
    output logic            head_valid,
    output wb_entry_t       age_entry [DEPTH],
    output logic [DEPTH-1:0] age_valid
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("wb_fifo DEPTH must be a power of two and at least 2");
    end

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign age_entry[k] = mem[rd_ptr + PW'(k)];
        assign age_valid[k] = (CW'(k) < count);
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU: queues results, writes them to the register
// file under a grant handshake, commits condition codes and forwards queued data.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    parameter  int CND_W = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_alu_out,
    input  logic [3:0]       i_alu_action,
    input  logic [3:0]       i_dst,
    input  logic             i_wen,
    output logic             o_rf_we,
    output logic [3:0]       o_rf_waddr,
    output logic [31:0]      o_rf_wdata,
    input  logic             i_rf_ready,
    output logic [CND_W-1:0] o_cnd,
    input  logic [3:0]       i_fwd_addr,
    output logic             o_fwd_hit,
    output logic [31:0]      o_fwd_data,
    output logic [CW-1:0]    o_count
);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        age_entry [DEPTH];
    logic [DEPTH-1:0] age_valid;
    logic             head_valid;
    logic             head_cnd;
    logic             head_rf;
    logic             push;
    logic             pop;

    assign push_entry = '{data: i_alu_out, action: i_alu_action, dst: i_dst, wen: i_wen};

    // Ready depends only on occupancy, so a full queue refuses a push even on a pop cycle.
    assign o_ready = (o_count != CW'(DEPTH));
    assign push    = i_valid && o_ready;

    assign head_cnd = head_valid && is_cnd(head.action);
    assign head_rf  = head_valid && needs_rf(head);
    assign pop      = head_valid && (!head_rf || i_rf_ready);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (o_count),
        .head       (head),
        .head_valid (head_valid),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    assign o_rf_we    = head_rf;
    assign o_rf_waddr = head_valid ? head.dst  : 4'd0;
    assign o_rf_wdata = head_valid ? head.data : 32'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnd <= '0;
        end else if (pop && head_cnd) begin
            o_cnd <= head.data[CND_W-1:0];
        end
    end

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && needs_rf(age_entry[k]) && age_entry[k].dst == i_fwd_addr) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = age_entry[k].data;
            end
        end
    end

endmodule
